// File: rtl/axi_ram_slave.sv
// AXI3 slave RAM: independent read and write FSMs sharing one word-addressed array,
// with programmable latency between address/data handshakes and the responses.
module axi_ram_slave #(
   parameter int ADDR_WIDTH = 12,
   parameter int RD_DELAY   = 1,
   parameter int WR_DELAY   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [15:0] RD_WAIT_LAST = (RD_DELAY > 0) ? 16'(RD_DELAY - 1) : 16'd0;
   localparam logic [15:0] WR_WAIT_LAST = (WR_DELAY > 0) ? 16'(WR_DELAY - 1) : 16'd0;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

   logic [31:0] mem [DEPTH];

   r_state_t              r_state;
   r_state_t              r_state_next;
   logic [3:0]            r_id;
   logic [ADDR_WIDTH-1:0] r_index;
   logic [ADDR_WIDTH-1:0] r_fetch_index;
   logic [7:0]            r_len;
   logic [7:0]            r_beat;
   logic [15:0]           r_cnt;
   logic [31:0]           r_data;
   logic [31:0]           r_fetch_word;
   logic                  r_load;
   logic                  r_advance;

   w_state_t              w_state;
   w_state_t              w_state_next;
   logic [3:0]            w_id;
   logic [ADDR_WIDTH-1:0] w_index;
   logic [15:0]           w_cnt;
   logic                  w_commit;

   logic                  unused_inputs;

   // Size, burst type, write length and write ID are fixed by the bridge, so they are not decoded.
   assign unused_inputs = ^{arsize, arburst, awlen, awsize, wid, wlast, araddr, awaddr};

   assign rid   = r_id;
   assign rdata = r_data;
   assign rresp = 2'b00;
   assign bid   = w_id;
   assign bresp = 2'b00;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
      end else begin
         r_state <= r_state_next;
         w_state <= w_state_next;
      end
   end

   always_comb begin
      r_state_next  = r_state;
      arready       = 1'b0;
      rvalid        = 1'b0;
      rlast         = 1'b0;
      r_load        = 1'b0;
      r_advance     = 1'b0;
      r_fetch_index = r_index;
      case (r_state)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) begin
               if (RD_DELAY == 0) begin
                  r_state_next  = R_DATA;
                  r_load        = 1'b1;
                  r_fetch_index = araddr[ADDR_WIDTH+1:2];
               end else begin
                  r_state_next = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (r_cnt == RD_WAIT_LAST) begin
               r_state_next = R_DATA;
               r_load       = 1'b1;
            end
         end
         R_DATA: begin
            rvalid = 1'b1;
            rlast  = (r_beat == r_len);
            if (rready) begin
               if (r_beat == r_len) begin
                  r_state_next = R_IDLE;
               end else begin
                  r_advance     = 1'b1;
                  r_load        = 1'b1;
                  r_fetch_index = r_index + ADDR_WIDTH'(1);
               end
            end
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   // A write committing on the same edge a beat is captured is merged in, so it shows up on that beat.
   always_comb begin
      r_fetch_word = mem[r_fetch_index];
      if (w_commit && (w_index == r_fetch_index)) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
               r_fetch_word[8*i +: 8] = wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_id    <= '0;
         r_index <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
      end else begin
         if (r_state == R_IDLE && arvalid) begin
            r_id    <= arid;
            r_index <= araddr[ADDR_WIDTH+1:2];
            r_len   <= arlen;
            r_beat  <= '0;
            r_cnt   <= '0;
         end
         if (r_state == R_WAIT) begin
            r_cnt <= r_cnt + 16'd1;
         end
         if (r_advance) begin
            r_index <= r_index + ADDR_WIDTH'(1);
            r_beat  <= r_beat + 8'd1;
         end
         if (r_load) begin
            r_data <= r_fetch_word;
         end
      end
   end

   always_comb begin
      w_state_next = w_state;
      awready      = 1'b0;
      wready       = 1'b0;
      bvalid       = 1'b0;
      w_commit     = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = 1'b1;
            if (awvalid) begin
               w_state_next = W_DATA;
            end
         end
         W_DATA: begin
            wready = 1'b1;
            if (wvalid) begin
               w_commit     = 1'b1;
               w_state_next = (WR_DELAY > 0) ? W_WAIT : W_RESP;
            end
         end
         W_WAIT: begin
            if (w_cnt == WR_WAIT_LAST) begin
               w_state_next = W_RESP;
            end
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) begin
               w_state_next = W_IDLE;
            end
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_id    <= '0;
         w_index <= '0;
         w_cnt   <= '0;
      end else begin
         if (w_state == W_IDLE && awvalid) begin
            w_id    <= awid;
            w_index <= awaddr[ADDR_WIDTH+1:2];
         end
         if (w_commit) begin
            w_cnt <= '0;
         end else if (w_state == W_WAIT) begin
            w_cnt <= w_cnt + 16'd1;
         end
      end
   end

   // Array has no reset; a write in the reset cycle is dropped along with the transaction.
   always_ff @(posedge clk) begin
      if (w_commit && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
               mem[w_index][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomized scoreboard bench for axi_ram_slave: a word-array model predicts every R beat
// and B response; a negedge monitor compares whatever the DUT presents against the queues.
module tb_axi_ram_slave;

   localparam int ADDR_WIDTH = 8;
   localparam int RD_DELAY   = 1;
   localparam int WR_DELAY   = 0;
   localparam int DEPTH      = 1 << ADDR_WIDTH;
   localparam int TIMEOUT    = 300;

   logic        clk;
   logic        reset;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
      logic        last;
      int          firstCycle;
   } rexp_t;

   typedef struct {
      logic [3:0] id;
      int         firstCycle;
   } bexp_t;

   rexp_t       rexp[$];
   bexp_t       bexp[$];
   logic [31:0] modelMem [DEPTH];

   int cyc         = 0;
   int checkCount  = 0;
   int passCount   = 0;
   int stallBeat   = -1;
   int stallLeft   = 0;
   int beatsPopped = 0;
   bit randomBackpressure = 0;

   bit    rActive   = 0;
   bit    bActive   = 0;
   bit    idleNext  = 0;
   bit    awPending = 0;
   rexp_t monBeat;

   axi_ram_slave #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .RD_DELAY  (RD_DELAY),
      .WR_DELAY  (WR_DELAY)
   ) dut (
      .clk(clk), .reset(reset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic reportTimeout(input string name);
      checkCount++;
      $display("[TB] FAIL %s: no completion within %0d cycles, expected completion", name, TIMEOUT);
   endtask

   // Ready generation: optional directed stall on one beat, otherwise random or always-ready.
   initial begin
      rready = 1'b1;
      bready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rvalid && stallLeft > 0 && beatsPopped == stallBeat) begin
            rready = 1'b0;
            stallLeft--;
         end else begin
            rready = randomBackpressure ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         bready = randomBackpressure ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // Monitor: compares every presented beat/response against the head of its queue.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            rActive     = 0;
            bActive     = 0;
            idleNext    = 0;
            awPending   = 0;
            beatsPopped = 0;
         end else begin
            if (idleNext) begin
               checkOutput("arready_after_rlast", 32'(arready), 32'd1);
               checkOutput("rvalid_after_rlast", 32'(rvalid), 32'd0);
               idleNext = 0;
            end
            if (rvalid) begin
               if (rexp.size() == 0) begin
                  checkCount++;
                  $display("[TB] FAIL unexpected_rbeat: got rvalid=1 rdata=0x%08h at cycle %0d, expected no beat", rdata, cyc);
               end else begin
                  if (!rActive) begin
                     checkOutput("rvalid_latency", cyc, rexp[0].firstCycle);
                     checkOutput("arready_during_burst", 32'(arready), 32'd0);
                     rActive = 1;
                  end
                  checkOutput("rid", 32'(rid), 32'(rexp[0].id));
                  checkOutput("rdata", rdata, rexp[0].data);
                  checkOutput("rlast", 32'(rlast), 32'(rexp[0].last));
                  checkOutput("rresp", 32'(rresp), 32'd0);
                  if (rready) begin
                     monBeat = rexp.pop_front();
                     if (monBeat.last) begin
                        rActive     = 0;
                        idleNext    = 1;
                        beatsPopped = 0;
                     end else begin
                        beatsPopped++;
                     end
                  end
               end
            end
            if (wvalid && !awPending) begin
               checkOutput("wready_before_aw", 32'(wready), 32'd0);
            end
            if (awvalid && awready) awPending = 1;
            if (wvalid && wready) awPending = 0;
            if (bvalid) begin
               if (bexp.size() == 0) begin
                  checkCount++;
                  $display("[TB] FAIL unexpected_bresp: got bvalid=1 bid=%0d at cycle %0d, expected no response", bid, cyc);
               end else begin
                  if (!bActive) begin
                     checkOutput("bvalid_latency", cyc, bexp[0].firstCycle);
                     bActive = 1;
                  end
                  checkOutput("bid", 32'(bid), 32'(bexp[0].id));
                  checkOutput("bresp", 32'(bresp), 32'd0);
                  if (bready) begin
                     void'(bexp.pop_front());
                     bActive = 0;
                  end
               end
            end
         end
      end
   end

   task automatic waitDrain(input string name);
      bit done = 0;
      for (int i = 0; i < TIMEOUT && !done; i++) begin
         @(negedge clk);
         if (rexp.size() == 0 && bexp.size() == 0) done = 1;
      end
      if (!done) begin
         reportTimeout(name);
         rexp.delete();
         bexp.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // Called and returns at posedge+1; waits for the B response before returning.
   task automatic axiWrite(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                           input logic [3:0] strb, input bit early);
      bit    done = 0;
      int    idx;
      bexp_t be;
      wdata = data;
      wstrb = strb;
      wid   = id;
      wlast = 1'b1;
      if (early) begin
         wvalid = 1'b1;
         repeat (2) @(posedge clk);
         #1;
      end
      awaddr  = addr;
      awid    = id;
      awlen   = 8'd0;
      awsize  = 3'd2;
      awvalid = 1'b1;
      for (int i = 0; i < TIMEOUT && !done; i++) begin
         @(negedge clk);
         if (awready) done = 1;
         @(posedge clk);
         #1;
      end
      awvalid = 1'b0;
      if (!done) begin
         wvalid = 1'b0;
         reportTimeout("aw_handshake");
         return;
      end
      wvalid = 1'b1;
      done   = 0;
      for (int i = 0; i < TIMEOUT && !done; i++) begin
         @(negedge clk);
         if (wready) begin
            done = 1;
            idx  = int'((addr >> 2) % DEPTH);
            for (int b = 0; b < 4; b++) begin
               if (strb[b]) modelMem[idx][8*b +: 8] = data[8*b +: 8];
            end
            be.id         = id;
            be.firstCycle = cyc + WR_DELAY + 1;
            bexp.push_back(be);
         end
         @(posedge clk);
         #1;
      end
      wvalid = 1'b0;
      if (!done) begin
         reportTimeout("w_handshake");
         return;
      end
      waitDrain("write_resp");
   endtask

   // Issues the AR and queues the predicted beats; caller drains.
   task automatic axiRead(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
      bit    done = 0;
      int    base;
      rexp_t e;
      araddr  = addr;
      arid    = id;
      arlen   = len;
      arsize  = 3'd2;
      arburst = 2'd1;
      arvalid = 1'b1;
      for (int i = 0; i < TIMEOUT && !done; i++) begin
         @(negedge clk);
         if (arready) begin
            done = 1;
            base = int'((addr >> 2) % DEPTH);
            for (int b = 0; b <= int'(len); b++) begin
               e.id         = id;
               e.data       = modelMem[(base + b) % DEPTH];
               e.last       = (b == int'(len));
               e.firstCycle = (b == 0) ? cyc + RD_DELAY + 1 : -1;
               rexp.push_back(e);
            end
         end
         @(posedge clk);
         #1;
      end
      arvalid = 1'b0;
      if (!done) reportTimeout("ar_handshake");
   endtask

   task automatic applyStimulus();
      bit done = 0;
      // Fill the whole array so every later read has a defined expected word.
      for (int i = 0; i < DEPTH; i++) begin
         axiWrite(32'(i * 4), 4'($urandom), $urandom, 4'hF, 1'b0);
      end

      axiWrite(32'h10, 4'd1, 32'hDEADBEEF, 4'hF, 1'b0);
      axiRead(32'h10, 4'd1, 8'd0);
      waitDrain("single_read");

      for (int k = 0; k < 4; k++) begin
         axiWrite(32'h100 + 32'(4 * k), 4'd0, 32'hA0 + 32'(k), 4'hF, 1'b0);
      end
      axiRead(32'h100, 4'd0, 8'd3);
      waitDrain("icache_burst");

      stallBeat = 1;
      stallLeft = 3;
      axiRead(32'h100, 4'd0, 8'd3);
      waitDrain("burst_backpressure");
      stallBeat = -1;
      stallLeft = 0;

      axiWrite(32'h20, 4'd2, 32'h11223344, 4'hF, 1'b0);
      axiWrite(32'h20, 4'd1, 32'hAABBCCDD, 4'b0101, 1'b0);
      axiRead(32'h20, 4'd3, 8'd0);
      waitDrain("byte_write_read");

      axiWrite(32'h44, 4'd5, 32'hCAFEF00D, 4'hF, 1'b1);
      axiRead(32'h44, 4'd6, 8'd0);
      waitDrain("early_wvalid_read");

      axiRead(32'hABCDE3FF, 4'd7, 8'd3);
      waitDrain("wrap_read");

      axiRead(32'h100, 4'd2, 8'd3);
      for (int i = 0; i < TIMEOUT && !done; i++) begin
         if (rexp.size() == 3) begin
            done = 1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) reportTimeout("reset_burst_beat2");
      reset = 1'b1;
      rexp.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset_mid_burst_rvalid", 32'(rvalid), 32'd0);
      checkOutput("reset_mid_burst_arready", 32'(arready), 32'd1);
      checkOutput("reset_mid_burst_rlast", 32'(rlast), 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         checkOutput("no_beat_after_reset", 32'(rvalid), 32'd0);
      end
      axiRead(32'h104, 4'd4, 8'd1);
      waitDrain("read_after_reset");

      randomBackpressure = 1;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            axiWrite($urandom, 4'($urandom), $urandom, 4'($urandom), bit'($urandom_range(0, 1)));
         end else begin
            axiRead($urandom, 4'($urandom), 8'($urandom_range(0, 7)));
            waitDrain("random_read");
         end
      end
      randomBackpressure = 0;
   endtask

   initial begin
      reset   = 1'b1;
      arid    = '0;
      araddr  = '0;
      arlen   = '0;
      arsize  = '0;
      arburst = '0;
      arvalid = 1'b0;
      awid    = '0;
      awaddr  = '0;
      awlen   = '0;
      awsize  = '0;
      awvalid = 1'b0;
      wid     = '0;
      wdata   = '0;
      wstrb   = '0;
      wlast   = 1'b0;
      wvalid  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_arready", 32'(arready), 32'd1);
      checkOutput("reset_awready", 32'(awready), 32'd1);
      checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
      checkOutput("reset_rlast", 32'(rlast), 32'd0);
      checkOutput("reset_wready", 32'(wready), 32'd0);
      checkOutput("reset_bvalid", 32'(bvalid), 32'd0);
      checkOutput("reset_rid", 32'(rid), 32'd0);
      checkOutput("reset_bid", 32'(bid), 32'd0);
      checkOutput("reset_rdata", rdata, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
